load_align_unit: RTL and testbench

LOAD_ALIGN_UNIT -- requirements
Module: load_align_unit

---
 rtl/load_align_unit_if.sv | 34 +++
 rtl/load_align_unit.sv | 154 +++++++++++++++
 tb/tb_load_align_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/load_align_unit_if.sv
// load_align_unit_if
// Bundles the request, memory and result signals of the load alignment unit.
//   Request side : req_valid, req_ready, req_addr, req_size, req_unsigned
//   Memory side  : mem_req, mem_addr, mem_ack, mem_rdata
//   Result side  : load_valid, load_data, load_err
// Modport slave is the unit's own view; modport master is the view of
// whatever drives requests and answers memory reads.
interface load_align_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_err;

  modport slave (
    input  req_valid, req_addr, req_size, req_unsigned, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_addr, load_valid, load_data, load_err
  );

  modport master (
    output req_valid, req_addr, req_size, req_unsigned, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_addr, load_valid, load_data, load_err
  );
endinterface

// File: rtl/load_align_unit.sv
// load_align_unit
// Accepts one load request at a time, issues a word-aligned memory read,
// picks the addressed byte/half/word/dword lane out of the returned word
// (little-endian) and sign- or zero-extends it to DATA_W bits.
// Ports:
//   clk   - single clock, rising edge
//   reset - synchronous, active-high
//   bus   - load_align_unit_if.slave (request, memory and result signals)
// Parameters: DATA_W (32 or 64), ADDR_W (byte address width, >= 3).
// Optional feature: define LOAD_MISALIGN_CHECK_EN to reject requests that are
// not naturally aligned to their size with a load_err pulse instead of reading
// memory. Without it, misaligned lanes that run off the top of the word are
// filled with zero bytes before extension.
module load_align_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input logic             clk,
  input logic             reset,
  load_align_unit_if.slave bus
);

  localparam int OFF_W = (DATA_W == 64) ? 3 : 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_MEM,
    RESP
  } stateT;

  stateT             stateQ, stateD;
  logic [ADDR_W-1:0] addrQ;
  logic [1:0]        sizeQ;
  logic              unsignedQ;
  logic              errQ;
  logic [DATA_W-1:0] loadDataQ;

  logic              accept;
  logic              misaligned;
  logic              illegal;
  logic [DATA_W-1:0] laneShift;
  logic [DATA_W-1:0] laneMask;
  logic [DATA_W-1:0] extData;
  logic [6:0]        laneBits;
  logic              signBit;

  assign accept = bus.req_valid && (stateQ == IDLE);

  // Alignment screening of the incoming request. Only active when the
  // misalignment check is built in; otherwise every size/offset goes to memory.
  always_comb begin
    misaligned = 1'b0;
`ifdef LOAD_MISALIGN_CHECK_EN
    case (bus.req_size)
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      2'b11:   misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
`endif
  end

  // A dword cannot be served by a 32-bit memory word, so it is rejected
  // up front together with any misaligned request.
  assign illegal = ((bus.req_size == 2'b11) && (DATA_W == 32)) || misaligned;

  // Lane extraction: shift the addressed byte down to bit 0 (bytes above the
  // word boundary shift in as zero), mask to the access width, then fill the
  // upper bits with the sign when a signed load has its top lane bit set.
  // The mask trick also covers full-width accesses: shifting 1 by DATA_W gives
  // 0, and 0 - 1 is all ones, so the lane passes through untouched.
  always_comb begin
    laneShift = bus.mem_rdata >> {addrQ[OFF_W-1:0], 3'b000};
    laneBits  = 7'd8;
    signBit   = laneShift[7];
    case (sizeQ)
      2'b00: begin
        laneBits = 7'd8;
        signBit  = laneShift[7];
      end
      2'b01: begin
        laneBits = 7'd16;
        signBit  = laneShift[15];
      end
      2'b10: begin
        laneBits = 7'd32;
        signBit  = laneShift[31];
      end
      default: begin
        laneBits = 7'd64;
        signBit  = laneShift[DATA_W-1];
      end
    endcase
    laneMask = (DATA_W'(1) << laneBits) - DATA_W'(1);
    extData  = laneShift & laneMask;
    if (!unsignedQ && signBit) begin
      extData = extData | ~laneMask;
    end
  end

  // Next-state logic. Illegal requests skip memory entirely and go straight
  // to RESP, where errQ turns the result strobe into an error strobe.
  always_comb begin
    stateD = stateQ;
    case (stateQ)
      IDLE: begin
        if (accept) begin
          stateD = illegal ? RESP : WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (bus.mem_ack) begin
          stateD = RESP;
        end
      end
      RESP:    stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  // State and request registers. The request fields only load on acceptance,
  // so traffic presented while busy cannot disturb an access in flight.
  // The result register only loads on the acknowledging WAIT_MEM cycle and
  // otherwise holds, which keeps load_data stable outside RESP.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ    <= IDLE;
      addrQ     <= '0;
      sizeQ     <= 2'b00;
      unsignedQ <= 1'b0;
      errQ      <= 1'b0;
      loadDataQ <= '0;
    end else begin
      stateQ <= stateD;
      if (accept) begin
        addrQ     <= bus.req_addr;
        sizeQ     <= bus.req_size;
        unsignedQ <= bus.req_unsigned;
        errQ      <= illegal;
      end
      if ((stateQ == WAIT_MEM) && bus.mem_ack) begin
        loadDataQ <= extData;
      end
    end
  end

  assign bus.req_ready  = (stateQ == IDLE);
  assign bus.mem_req    = (stateQ == WAIT_MEM);
  assign bus.mem_addr   = {addrQ[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign bus.load_valid = (stateQ == RESP) && !errQ;
  assign bus.load_err   = (stateQ == RESP) && errQ;
  assign bus.load_data  = loadDataQ;

endmodule

// File: tb/tb_load_align_unit.sv
// tb_load_align_unit
// Directed bench for load_align_unit. One 32-bit and one 64-bit instance share
// the clock and reset; a select bit routes the request/memory stimulus to one
// of them and muxes that instance's outputs into common observation nets.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        reqValid;
  logic [31:0] reqAddr;
  logic [1:0]  reqSize;
  logic        reqUns;
  logic        memAck;
  logic [63:0] memRdata;

  logic        readyObs;
  logic        memReqObs;
  logic [31:0] memAddrObs;
  logic        loadValidObs;
  logic        loadErrObs;
  logic [63:0] loadDataObs;

  int errors = 0;
  int checks = 0;
  logic [63:0] last32;
  logic [63:0] last64;

  load_align_unit_if #(.DATA_W(32), .ADDR_W(32)) b32 ();
  load_align_unit_if #(.DATA_W(64), .ADDR_W(32)) b64 ();

  load_align_unit #(.DATA_W(32), .ADDR_W(32)) u32 (.clk(clk), .reset(reset), .bus(b32));
  load_align_unit #(.DATA_W(64), .ADDR_W(32)) u64 (.clk(clk), .reset(reset), .bus(b64));

  assign b32.req_valid    = reqValid & ~sel;
  assign b32.req_addr     = reqAddr;
  assign b32.req_size     = reqSize;
  assign b32.req_unsigned = reqUns;
  assign b32.mem_ack      = memAck & ~sel;
  assign b32.mem_rdata    = memRdata[31:0];

  assign b64.req_valid    = reqValid & sel;
  assign b64.req_addr     = reqAddr;
  assign b64.req_size     = reqSize;
  assign b64.req_unsigned = reqUns;
  assign b64.mem_ack      = memAck & sel;
  assign b64.mem_rdata    = memRdata;

  assign readyObs     = sel ? b64.req_ready  : b32.req_ready;
  assign memReqObs    = sel ? b64.mem_req    : b32.mem_req;
  assign memAddrObs   = sel ? b64.mem_addr   : b32.mem_addr;
  assign loadValidObs = sel ? b64.load_valid : b32.load_valid;
  assign loadErrObs   = sel ? b64.load_err   : b32.load_err;
  assign loadDataObs  = sel ? b64.load_data  : {32'h0, b32.load_data};

  always #5 clk = ~clk;

  // Safety net so the run always ends even if sequencing goes wrong.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One legal load: accept, wait waitCycles WAIT_MEM cycles (ack in the last),
  // then check the RESP pulse and the held result afterwards. While busy, a
  // conflicting request is presented to prove it is ignored.
  task automatic applyStimulus(input string tag, input bit wide,
                               input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [63:0] rdata,
                               input int waitCycles, input logic [63:0] expData);
    logic [31:0] expAddr;
    expAddr  = wide ? (addr & ~32'h7) : (addr & ~32'h3);
    sel      = wide;
    reqAddr  = addr;
    reqSize  = size;
    reqUns   = uns;
    reqValid = 1'b1;
    #1;
    checkOutput({tag, " ready"}, readyObs, 1);
    step();
    reqAddr = ~addr;
    reqSize = 2'b00;
    reqUns  = ~uns;
    for (int i = 1; i <= waitCycles; i++) begin
      checkOutput({tag, " memReq"}, memReqObs, 1);
      checkOutput({tag, " memAddr"}, memAddrObs, expAddr);
      checkOutput({tag, " earlyValid"}, loadValidObs, 0);
      if (i == waitCycles) begin
        memAck   = 1'b1;
        memRdata = rdata;
        reqValid = 1'b0;
      end else begin
        memRdata = {$urandom, $urandom};
      end
      step();
    end
    memAck = 1'b0;
    checkOutput({tag, " valid"}, loadValidObs, 1);
    checkOutput({tag, " err"}, loadErrObs, 0);
    checkOutput({tag, " data"}, loadDataObs, expData);
    checkOutput({tag, " memReqOff"}, memReqObs, 0);
    step();
    checkOutput({tag, " validOff"}, loadValidObs, 0);
    checkOutput({tag, " readyBack"}, readyObs, 1);
    checkOutput({tag, " dataHeld"}, loadDataObs, expData);
  endtask

  // A request that must be rejected: no memory read, one load_err cycle,
  // result register untouched, then ready again.
  task automatic applyError(input string tag, input bit wide,
                            input logic [31:0] addr, input logic [1:0] size,
                            input logic [63:0] holdData);
    sel      = wide;
    reqAddr  = addr;
    reqSize  = size;
    reqUns   = 1'b0;
    reqValid = 1'b1;
    #1;
    checkOutput({tag, " ready"}, readyObs, 1);
    step();
    reqValid = 1'b0;
    checkOutput({tag, " noMemReq"}, memReqObs, 0);
    checkOutput({tag, " err"}, loadErrObs, 1);
    checkOutput({tag, " noValid"}, loadValidObs, 0);
    checkOutput({tag, " busy"}, readyObs, 0);
    checkOutput({tag, " dataHeld"}, loadDataObs, holdData);
    step();
    checkOutput({tag, " errOff"}, loadErrObs, 0);
    checkOutput({tag, " readyBack"}, readyObs, 1);
    checkOutput({tag, " noMemReq2"}, memReqObs, 0);
  endtask

  initial begin
    reset    = 1'b1;
    sel      = 1'b0;
    reqValid = 1'b0;
    reqAddr  = 32'h0;
    reqSize  = 2'b00;
    reqUns   = 1'b0;
    memAck   = 1'b0;
    memRdata = 64'h0;
    repeat (2) step();

    // Reset state of both instances
    checkOutput("rst32 ready", readyObs, 1);
    checkOutput("rst32 memReq", memReqObs, 0);
    checkOutput("rst32 memAddr", memAddrObs, 0);
    checkOutput("rst32 valid", loadValidObs, 0);
    checkOutput("rst32 err", loadErrObs, 0);
    checkOutput("rst32 data", loadDataObs, 0);
    sel = 1'b1;
    #1;
    checkOutput("rst64 ready", readyObs, 1);
    checkOutput("rst64 memReq", memReqObs, 0);
    checkOutput("rst64 data", loadDataObs, 0);
    sel   = 1'b0;
    reset = 1'b0;
    step();
    checkOutput("postRst ready", readyObs, 1);

    // 32-bit loads
    applyStimulus("byteS3", 0, 32'h3, 2'b00, 0, 64'h80FF_FFFF, 1, 64'hFFFF_FF80);
    applyStimulus("halfU2", 0, 32'h2, 2'b01, 1, 64'h9FFF_1234, 2, 64'h0000_9FFF);
    applyStimulus("byteU1", 0, 32'h1001, 2'b00, 1, 64'h1234_A5CD, 1, 64'h0000_00A5);
    applyStimulus("halfS0", 0, 32'h20, 2'b01, 0, 64'h0000_8001, 3, 64'hFFFF_8001);
    applyStimulus("wordS0", 0, 32'h44, 2'b10, 0, 64'h89AB_CDEF, 1, 64'h89AB_CDEF);
    applyStimulus("byteS0", 0, 32'h8, 2'b00, 0, 64'hFFFF_FF7F, 1, 64'h0000_007F);
    last32 = 64'h7F;
`ifdef LOAD_MISALIGN_CHECK_EN
    applyError("misHalf3", 0, 32'h3, 2'b01, last32);
`else
    applyStimulus("misHalf3", 0, 32'h3, 2'b01, 0, 64'h8000_0000, 1, 64'h0000_0080);
    last32 = 64'h80;
`endif
    applyError("dword32", 0, 32'h0, 2'b11, last32);

    // 64-bit loads
    applyStimulus("wordS4", 1, 32'h4, 2'b10, 0, 64'h8000_0000_0000_0000, 5,
                  64'hFFFF_FFFF_8000_0000);
    applyStimulus("byteS7", 1, 32'h17, 2'b00, 0, 64'h8500_0000_0000_0000, 1,
                  64'hFFFF_FFFF_FFFF_FF85);
    applyStimulus("dword8", 1, 32'h8, 2'b11, 0, 64'h0123_4567_89AB_CDEF, 1,
                  64'h0123_4567_89AB_CDEF);
    applyStimulus("wordU4", 1, 32'h4, 2'b10, 1, 64'hF000_0000_0000_0000, 2,
                  64'h0000_0000_F000_0000);
    last64 = 64'h0000_0000_F000_0000;
`ifdef LOAD_MISALIGN_CHECK_EN
    applyError("misWord6", 1, 32'h6, 2'b10, last64);
`else
    applyStimulus("misWord6", 1, 32'h6, 2'b10, 0, 64'hABCD_0000_0000_0000, 1,
                  64'h0000_0000_0000_ABCD);
`endif

    // Reset while waiting on memory, then a late acknowledge
    sel      = 1'b0;
    reqAddr  = 32'h0;
    reqSize  = 2'b00;
    reqUns   = 1'b0;
    reqValid = 1'b1;
    step();
    reqValid = 1'b0;
    checkOutput("rstWait memReq", memReqObs, 1);
    reset = 1'b1;
    step();
    reset    = 1'b0;
    memAck   = 1'b1;
    memRdata = 64'h55;
    checkOutput("rstWait ready", readyObs, 1);
    checkOutput("rstWait memReqOff", memReqObs, 0);
    checkOutput("rstWait dataClr", loadDataObs, 0);
    step();
    memAck = 1'b0;
    checkOutput("rstWait noValid", loadValidObs, 0);
    checkOutput("rstWait readyStill", readyObs, 1);
    step();
    checkOutput("rstWait noValid2", loadValidObs, 0);
    checkOutput("rstWait dataStill", loadDataObs, 0);

    // Normal operation after the abandoned access
    applyStimulus("afterRst", 0, 32'h2, 2'b01, 0, 64'h7FFF_0000, 1, 64'h0000_7FFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
